shifter_operand_gen: RTL



---
 rtl/shifter_pkg.sv | 33 +++
 rtl/shift_core.sv | 62 ++++++
 rtl/shifter_operand_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and operand-2 field positions for the ARM7TDMI shifter operand generator.
package shifter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP2_W  = 12;
  localparam int unsigned AMT_W  = 8;

  // Operand-2 field positions (instruction bits [11:0])
  localparam int unsigned OP2_ROT_LSB   = 8;   // [11:8] rotate/2
  localparam int unsigned OP2_IMM8_LSB  = 0;   // [7:0]  immediate byte
  localparam int unsigned OP2_SHAMT_LSB = 7;   // [11:7] immediate shift amount
  localparam int unsigned OP2_TYPE_LSB  = 5;   // [6:5]  shift type
  localparam int unsigned OP2_REG_BIT   = 4;   // 1 = shift amount from Rs
  localparam int unsigned OP2_MUL_BIT   = 7;   // set with REG_BIT = multiply/extension space

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RS_FETCH = 2'd1,
    EXEC     = 2'd2
  } state_t;

  function automatic logic is_reg_shift(input logic imm, input logic [OP2_W-1:0] op2);
    return !imm && op2[OP2_REG_BIT];
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter covering ARM immediate-form and register-form shift semantics.
module shift_core
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [AMT_W-1:0]  amount,
  input  shift_t            shift_type,
  input  logic              carry_in,
  input  logic              imm_form,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [2*DATA_W-1:0] wide;
  logic [AMT_W-1:0]    amt;
  logic [AMT_W-1:0]    amt_asr;

  // Immediate form: a zero amount encodes LSR/ASR #32 and RRX.
  always_comb begin
    result  = value;
    carry   = carry_in;
    wide    = '0;
    amt     = amount;
    if (imm_form && (amount == '0) && ((shift_type == LSR) || (shift_type == ASR)))
      amt = AMT_W'(32);
    amt_asr = (amt > AMT_W'(32)) ? AMT_W'(32) : amt;

    if (imm_form && (amount == '0) && (shift_type == ROR)) begin
      result = {carry_in, value[DATA_W-1:1]};
      carry  = value[0];
    end else if (amt != '0) begin
      case (shift_type)
        LSL: begin
          wide   = {{DATA_W{1'b0}}, value} << amt;
          result = wide[DATA_W-1:0];
          carry  = wide[DATA_W];
        end
        LSR: begin
          wide   = {value, {DATA_W{1'b0}}} >> amt;
          result = wide[2*DATA_W-1:DATA_W];
          carry  = wide[DATA_W-1];
        end
        ASR: begin
          wide   = $signed({value, {DATA_W{1'b0}}}) >>> amt_asr;
          result = wide[2*DATA_W-1:DATA_W];
          carry  = wide[DATA_W-1];
        end
        default: begin
          if (amt[4:0] == 5'd0) begin
            result = value;
            carry  = value[DATA_W-1];
          end else begin
            wide   = {value, value} >> amt[4:0];
            result = wide[DATA_W-1:0];
            carry  = wide[DATA_W-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_operand_gen.sv
// ARM7TDMI data-processing operand-2 generator with valid/ready on both sides.
// Register-specified shifts (and the RS_FETCH state) exist only with SHIFTER_OPERAND_REGSHIFT_EN defined.
module shifter_operand_gen
  import shifter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm,
  input  logic [OP2_W-1:0]  op2,
  input  logic [DATA_W-1:0] rm_data,
  input  logic              carry_in,
  input  logic [DATA_W-1:0] rs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand,
  output logic              carry_out,
  output logic              err
);

  state_t state, state_nxt;

  logic              accept;
  logic              live_reg;
  logic              live_err;
  logic              to_rs;
  logic              load;
  logic [DATA_W-1:0] operand_nxt;
  logic              carry_nxt;
  logic              err_nxt;

  logic [DATA_W-1:0] core_value;
  logic [AMT_W-1:0]  core_amount;
  shift_t            core_type;
  logic              core_c;
  logic              core_imm_form;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;

  assign in_ready = (state == IDLE) || ((state == EXEC) && out_ready);
  assign accept   = in_valid && in_ready;
  assign live_reg = is_reg_shift(imm, op2);

`ifdef SHIFTER_OPERAND_REGSHIFT_EN
  logic [DATA_W-1:0] cap_rm;
  logic              cap_c;
  shift_t            cap_type;
  logic              unused_bits;

  assign live_err    = live_reg && op2[OP2_MUL_BIT];
  assign to_rs       = accept && live_reg && !live_err;
  assign unused_bits = ^{op2[3:0], rs_data[DATA_W-1:AMT_W]};

  // Register-shift operands are held while Rs is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_rm   <= '0;
      cap_c    <= 1'b0;
      cap_type <= LSL;
    end else if (accept) begin
      cap_rm   <= rm_data;
      cap_c    <= carry_in;
      cap_type <= shift_t'(op2[OP2_TYPE_LSB +: 2]);
    end
  end
`else
  logic unused_bits;

  assign live_err    = live_reg;
  assign to_rs       = 1'b0;
  assign unused_bits = ^{op2[3:0], rs_data};
`endif

  // Shifter input select: live request fields, or captured fields plus Rs.
  always_comb begin
    core_value    = rm_data;
    core_amount   = {3'b000, op2[OP2_SHAMT_LSB +: 5]};
    core_type     = shift_t'(op2[OP2_TYPE_LSB +: 2]);
    core_c        = carry_in;
    core_imm_form = 1'b1;
    if (imm) begin
      core_value    = {24'd0, op2[OP2_IMM8_LSB +: 8]};
      core_amount   = {3'b000, op2[OP2_ROT_LSB +: 4], 1'b0};
      core_type     = ROR;
      core_imm_form = 1'b0;
    end
`ifdef SHIFTER_OPERAND_REGSHIFT_EN
    if (state == RS_FETCH) begin
      core_value    = cap_rm;
      core_amount   = rs_data[AMT_W-1:0];
      core_type     = cap_type;
      core_c        = cap_c;
      core_imm_form = 1'b0;
    end
`endif
  end

  shift_core u_shift_core (
    .value      (core_value),
    .amount     (core_amount),
    .shift_type (core_type),
    .carry_in   (core_c),
    .imm_form   (core_imm_form),
    .result     (core_result),
    .carry      (core_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and result-register load decisions.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    operand_nxt = core_result;
    carry_nxt   = core_carry;
    err_nxt     = 1'b0;
    case (state)
      IDLE, EXEC: begin
        if (accept) begin
          if (to_rs) begin
            state_nxt = RS_FETCH;
          end else begin
            state_nxt = EXEC;
            load      = 1'b1;
            if (live_err) begin
              operand_nxt = rm_data;
              carry_nxt   = carry_in;
              err_nxt     = 1'b1;
            end
          end
        end else if ((state == EXEC) && out_ready) begin
          state_nxt = IDLE;
        end
      end
`ifdef SHIFTER_OPERAND_REGSHIFT_EN
      RS_FETCH: begin
        state_nxt = EXEC;
        load      = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      operand   <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= (state_nxt == EXEC);
      if (load) begin
        operand   <= operand_nxt;
        carry_out <= carry_nxt;
        err       <= err_nxt;
      end
    end
  end

endmodule
